// File: rtl/rs_pkg.sv
// Shared definitions for the RS(15,9) codec over GF(16).
// Contents: symbol/code geometry, GF(16) power table, generator coefficients,
// encoder FSM state type and the bit-level GF(16) multiplier.
package rs_pkg;

    localparam int unsigned SYM_W  = 4;
    localparam int unsigned RS_N   = 15;
    localparam int unsigned RS_K   = 9;
    localparam int unsigned RS_PAR = 6;

    typedef logic [SYM_W-1:0] sym_t;

    // alpha^i for primitive polynomial x^4+x+1, alpha = 4'b0010
    localparam sym_t ALPHA0  = 4'h1;
    localparam sym_t ALPHA1  = 4'h2;
    localparam sym_t ALPHA2  = 4'h4;
    localparam sym_t ALPHA3  = 4'h8;
    localparam sym_t ALPHA4  = 4'h3;
    localparam sym_t ALPHA5  = 4'h6;
    localparam sym_t ALPHA6  = 4'hC;
    localparam sym_t ALPHA7  = 4'hB;
    localparam sym_t ALPHA8  = 4'h5;
    localparam sym_t ALPHA9  = 4'hA;
    localparam sym_t ALPHA10 = 4'h7;
    localparam sym_t ALPHA11 = 4'hE;
    localparam sym_t ALPHA12 = 4'hF;
    localparam sym_t ALPHA13 = 4'hD;
    localparam sym_t ALPHA14 = 4'h9;

    // g(x) = prod_{i=1..6} (x + alpha^i); g6 = 1 is implicit
    localparam sym_t G0 = 4'hC;
    localparam sym_t G1 = 4'hA;
    localparam sym_t G2 = 4'hC;
    localparam sym_t G3 = 4'h3;
    localparam sym_t G4 = 4'h9;
    localparam sym_t G5 = 4'h7;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Carry-less product followed by reduction modulo x^4+x+1.
    function automatic sym_t gf16_mul(input sym_t a, input sym_t b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ ({3'b000, a} << i);
        end
        for (int i = 6; i >= 4; i--) begin
            if (p[i]) p = p ^ (7'b0010011 << (i - 4));
        end
        return p[3:0];
    endfunction

endpackage

// File: rtl/gf16_const_mul.sv
// GF(16) multiply of a symbol by a constant coefficient.
// Ports: operand - input symbol; product - operand * COEF.
module gf16_const_mul
    import rs_pkg::*;
#(
    parameter sym_t COEF = ALPHA0
) (
    input  sym_t operand,
    output sym_t product
);

    assign product = gf16_mul(operand, COEF);

endmodule

// File: rtl/rs_encoder_seq.sv
// Sequential systematic RS(15,9) encoder over GF(16), one message symbol per clock.
// Ports:
//   clk           - system clock, rising edge
//   reset         - asynchronous active-high reset
//   messageIn     - 9 symbols; symbol k at [4k+3:4k] lands at codeword position k+6
//   encodeMessage - start request, acted on at its rising edge
//   codeWordOut   - 15 symbols; position j at [4j+3:4j], held until next completion
//   codeWordValid - one-cycle pulse when codeWordOut updates
//   encoderBusy   - high while an encode is in progress
module rs_encoder_seq
    import rs_pkg::*;
#(
    parameter int unsigned N = 15,
    parameter int unsigned K = 9,
    parameter int unsigned M = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [K*M-1:0] messageIn,
    input  logic           encodeMessage,
    output logic [N*M-1:0] codeWordOut,
    output logic           codeWordValid,
    output logic           encoderBusy
);

    localparam logic [3:0] LAST_SHIFT = 4'(K - 1);
    localparam sym_t GEN [RS_PAR] = '{G0, G1, G2, G3, G4, G5};

    state_t               state;
    logic                 enc_prev;
    logic [3:0]           count;
    logic [K*M-1:0]       msg_latch;
    logic [K*M-1:0]       msg_shift;
    sym_t                 parity  [RS_PAR];
    sym_t                 fb_prod [RS_PAR];
    sym_t                 fb;
    logic                 start;
    logic [RS_PAR*M-1:0]  parity_flat;

    assign start = encodeMessage & ~enc_prev;

    // Highest message position is always at the top of the shift register.
    assign fb = msg_shift[K*M-1 -: M] ^ parity[RS_PAR-1];

    for (genvar i = 0; i < RS_PAR; i++) begin : g_fb_mul
        gf16_const_mul #(
            .COEF (GEN[i])
        ) u_mul (
            .operand (fb),
            .product (fb_prod[i])
        );
    end

    always_comb begin
        parity_flat = '0;
        for (int i = 0; i < RS_PAR; i++) begin
            parity_flat[i*M +: M] = parity[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            enc_prev      <= 1'b0;
            count         <= '0;
            msg_latch     <= '0;
            msg_shift     <= '0;
            for (int i = 0; i < RS_PAR; i++) parity[i] <= '0;
            codeWordOut   <= '0;
            codeWordValid <= 1'b0;
            encoderBusy   <= 1'b0;
        end else begin
            enc_prev      <= encodeMessage;
            codeWordValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Starts seen in SHIFT/DONE are dropped, not queued.
                    if (start) begin
                        msg_latch   <= messageIn;
                        msg_shift   <= messageIn;
                        for (int i = 0; i < RS_PAR; i++) parity[i] <= '0;
                        count       <= '0;
                        encoderBusy <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    parity[0] <= fb_prod[0];
                    for (int i = 1; i < RS_PAR; i++) begin
                        parity[i] <= parity[i-1] ^ fb_prod[i];
                    end
                    msg_shift <= {msg_shift[K*M-M-1:0], {M{1'b0}}};
                    count     <= count + 4'd1;
                    if (count == LAST_SHIFT) state <= DONE;
                end
                DONE: begin
                    codeWordOut   <= {msg_latch, parity_flat};
                    codeWordValid <= 1'b1;
                    encoderBusy   <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    encoderBusy <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_encoder_seq.sv
module tb_rs_encoder_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        encodeMessage;
    logic [35:0] messageIn;
    logic [59:0] codeWordOut;
    logic        codeWordValid;
    logic        encoderBusy;

    always #5 clk = ~clk;

    rs_encoder_seq dut (
        .clk           (clk),
        .reset         (reset),
        .messageIn     (messageIn),
        .encodeMessage (encodeMessage),
        .codeWordOut   (codeWordOut),
        .codeWordValid (codeWordValid),
        .encoderBusy   (encoderBusy)
    );

    int          checks = 0;
    int          errors = 0;
    int          valid_count = 0;
    longint      cyc = 0;
    longint      last_valid_cyc = 0;
    longint      prev_valid_cyc = 0;
    logic [59:0] exp_q[$];
    logic [35:0] msg_q[$];
    logic [59:0] mon_exp;
    logic [35:0] mon_msg;

    // GF(16) log/antilog model, independent of the RTL bit-level multiplier
    logic [3:0]  gexp [0:14];
    int          glog [0:15];
    logic [3:0]  gpoly [0:6];

    function automatic void init_tables();
        logic [3:0] v;
        logic [4:0] t;
        v = 4'h1;
        for (int i = 0; i < 15; i++) begin
            gexp[i] = v;
            glog[v] = i;
            t = {v, 1'b0};
            if (t[4]) t = t ^ 5'b10011;
            v = t[3:0];
        end
        gpoly[0] = 4'hC; gpoly[1] = 4'hA; gpoly[2] = 4'hC; gpoly[3] = 4'h3;
        gpoly[4] = 4'h9; gpoly[5] = 4'h7; gpoly[6] = 4'h1;
    endfunction

    function automatic logic [3:0] tmul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'h0 || b == 4'h0) return 4'h0;
        return gexp[(glog[a] + glog[b]) % 15];
    endfunction

    // Long division of m(x)*x^6 by g(x).
    function automatic logic [59:0] model_codeword(input logic [35:0] msg);
        logic [3:0]  c [0:14];
        logic [3:0]  coef;
        logic [59:0] r;
        for (int i = 0; i < 15; i++) c[i] = 4'h0;
        for (int k = 0; k < 9; k++) c[6+k] = msg[4*k +: 4];
        for (int d = 14; d >= 6; d--) begin
            coef = c[d];
            for (int i = 0; i <= 6; i++) c[d-6+i] = c[d-6+i] ^ tmul(coef, gpoly[i]);
        end
        r = '0;
        r[59:24] = msg;
        for (int i = 0; i < 6; i++) r[4*i +: 4] = c[i];
        return r;
    endfunction

    function automatic bit syndromes_zero(input logic [59:0] cw);
        logic [3:0] s;
        for (int j = 1; j <= 6; j++) begin
            s = 4'h0;
            for (int i = 0; i < 15; i++) s = s ^ tmul(cw[4*i +: 4], gexp[(i*j) % 15]);
            if (s != 4'h0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [35:0] rand36();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[35:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every valid pulse pops one expected codeword.
    always @(negedge clk) begin
        if (codeWordValid === 1'b1) begin
            valid_count    = valid_count + 1;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_valid: got codeword %h with nothing expected", codeWordOut);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_msg = msg_q.pop_front();
                if (codeWordOut !== mon_exp) begin
                    errors = errors + 1;
                    $display("FAIL codeword: got %h expected %h", codeWordOut, mon_exp);
                end
                checks = checks + 1;
                if (!syndromes_zero(codeWordOut)) begin
                    errors = errors + 1;
                    $display("FAIL syndromes: codeword %h has nonzero syndrome, expected all zero",
                             codeWordOut);
                end
                checks = checks + 1;
                if (codeWordOut[59:24] !== mon_msg) begin
                    errors = errors + 1;
                    $display("FAIL systematic: got %h expected %h", codeWordOut[59:24], mon_msg);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full encode with latency and pulse-width checks.
    task automatic run_encode(input logic [35:0] msg);
        int n;
        messageIn     = msg;
        encodeMessage = 1'b1;
        exp_q.push_back(model_codeword(msg));
        msg_q.push_back(msg);
        tick();
        encodeMessage = 1'b0;
        messageIn     = rand36();
        checks++;
        if (encoderBusy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b expected 1", encoderBusy);
        end
        n = 0;
        while (codeWordValid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL latency: got %0d edges expected 10", n);
        end
        checks++;
        if (encoderBusy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_valid: got %b expected 0", encoderBusy);
        end
        tick();
        checks++;
        if (codeWordValid !== 1'b0) begin
            errors++;
            $display("FAIL valid_width: got %b expected 0", codeWordValid);
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        encodeMessage = 1'b0;
        messageIn     = '0;
        repeat (3) tick();
        checks++;
        if (codeWordOut !== 60'h0) begin
            errors++;
            $display("FAIL reset_codeword: got %h expected 0", codeWordOut);
        end
        checks++;
        if (codeWordValid !== 1'b0 || encoderBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b busy=%b expected 0 0",
                     codeWordValid, encoderBusy);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_vectors();
        run_encode(36'h000000001);
        checks++;
        if (codeWordOut !== 60'h000000001793CAC) begin
            errors++;
            $display("FAIL gen_vector: got %h expected 000000001793CAC", codeWordOut);
        end
        run_encode(36'h000000002);
        checks++;
        if (codeWordOut !== 60'h000000002E16B7B) begin
            errors++;
            $display("FAIL scaled_vector: got %h expected 000000002E16B7B", codeWordOut);
        end
        run_encode(36'h123456789);
        run_encode(36'h000000000);
        checks++;
        if (codeWordOut !== 60'h0) begin
            errors++;
            $display("FAIL zero_vector: got %h expected 0", codeWordOut);
        end
    endtask

    task automatic test_reset_abort();
        int vc;
        run_encode(36'hA5A5A5A5A);
        messageIn     = 36'h0DEADBEEF;
        encodeMessage = 1'b1;
        tick();
        encodeMessage = 1'b0;
        repeat (3) tick();
        vc    = valid_count;
        reset = 1'b1;
        #1;
        checks++;
        if (codeWordOut !== 60'h0 || encoderBusy !== 1'b0 || codeWordValid !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: got cw=%h busy=%b valid=%b expected 0 0 0",
                     codeWordOut, encoderBusy, codeWordValid);
        end
        tick();
        reset = 1'b0;
        repeat (15) tick();
        checks++;
        if (valid_count != vc) begin
            errors++;
            $display("FAIL abort_no_valid: got %0d pulses expected 0", valid_count - vc);
        end
        run_encode(36'h0DEADBEEF);
    endtask

    task automatic test_random();
        run_encode(36'hFFFFFFFFF);
        for (int i = 0; i < 1000; i++) run_encode(rand36());
    endtask

    task automatic test_hold();
        int vc;
        vc            = valid_count;
        messageIn     = 36'h3C3C3C3C3;
        exp_q.push_back(model_codeword(36'h3C3C3C3C3));
        msg_q.push_back(36'h3C3C3C3C3);
        encodeMessage = 1'b1;
        repeat (30) tick();
        encodeMessage = 1'b0;
        repeat (15) tick();
        checks++;
        if (valid_count != vc + 1) begin
            errors++;
            $display("FAIL hold_single: got %0d pulses expected 1", valid_count - vc);
        end
    endtask

    task automatic test_busy_ignore();
        int vc;
        vc            = valid_count;
        messageIn     = 36'h111222333;
        exp_q.push_back(model_codeword(36'h111222333));
        msg_q.push_back(36'h111222333);
        encodeMessage = 1'b1;
        tick();
        encodeMessage = 1'b0;
        repeat (2) tick();
        messageIn     = 36'h999888777;
        encodeMessage = 1'b1;
        tick();
        encodeMessage = 1'b0;
        repeat (20) tick();
        checks++;
        if (valid_count != vc + 1) begin
            errors++;
            $display("FAIL busy_ignore_count: got %0d pulses expected 1", valid_count - vc);
        end
        checks++;
        if (codeWordOut !== model_codeword(36'h111222333)) begin
            errors++;
            $display("FAIL busy_ignore_cw: got %h expected %h",
                     codeWordOut, model_codeword(36'h111222333));
        end
        // Start landing on the DONE edge must be dropped, and holding it must not retrigger.
        vc            = valid_count;
        messageIn     = 36'h456456456;
        exp_q.push_back(model_codeword(36'h456456456));
        msg_q.push_back(36'h456456456);
        encodeMessage = 1'b1;
        tick();
        encodeMessage = 1'b0;
        repeat (9) tick();
        messageIn     = 36'h0000000F0;
        encodeMessage = 1'b1;
        repeat (25) tick();
        encodeMessage = 1'b0;
        tick();
        checks++;
        if (valid_count != vc + 1) begin
            errors++;
            $display("FAIL coincident_start: got %0d pulses expected 1", valid_count - vc);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int vc;
        vc            = valid_count;
        messageIn     = 36'hABCDEF012;
        exp_q.push_back(model_codeword(36'hABCDEF012));
        msg_q.push_back(36'hABCDEF012);
        encodeMessage = 1'b1;
        tick();
        encodeMessage = 1'b0;
        repeat (10) tick();
        checks++;
        if (codeWordValid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_valid: got %b expected 1", codeWordValid);
        end
        messageIn     = 36'h543210FED;
        exp_q.push_back(model_codeword(36'h543210FED));
        msg_q.push_back(36'h543210FED);
        encodeMessage = 1'b1;
        tick();
        encodeMessage = 1'b0;
        n = 0;
        while (codeWordValid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL b2b_latency: got %0d edges expected 10", n);
        end
        tick();
        checks++;
        if (valid_count != vc + 2 || (last_valid_cyc - prev_valid_cyc) != 11) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d pulses %0d cycles apart expected 2 and 11",
                     valid_count - vc, last_valid_cyc - prev_valid_cyc);
        end
    endtask

    initial begin
        init_tables();
        reset         = 1'b0;
        encodeMessage = 1'b0;
        messageIn     = '0;
        #2;
        test_reset();
        test_vectors();
        test_reset_abort();
        test_hold();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
